bcd_to_binary: RTL and testbench

- Sequential converter that takes a packed multi-digit BCD value and produces its unsigned binary equivalent.
- It performs the reverse of the BCD addition and display path. It accepts the BCD digit results of the BCD adder stage, such as a 3-digit sum of two 2-digit BCD operands, and returns a binary value for downstream arithmetic.
- Processing is iterative, one digit per clock, most significant digit first, using acc = acc*10 + digit.
- A start/done handshake controls each conversion. Any digit greater than 9 is flagged as an error.

---
 rtl/bcd_to_binary_if.sv | 15 +
 rtl/bcd_to_binary.sv | 104 ++++++++++
 tb/tb_bcd_to_binary.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_if.sv
// Start/result bundle for the BCD-to-binary converter; master requests, slave converts.
interface bcd_to_binary_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [BIN_W-1:0]      bin_out;

  modport master (output start, bcd_in, input busy, done, error, bin_out);
  modport slave  (input start, bcd_in, output busy, done, error, bin_out);
endinterface

// File: rtl/bcd_to_binary.sv
// Iterative BCD-to-binary converter, one digit per clock MSD first; done DIGITS+1 edges after start
// (1 edge on a bad digit); start is ignored while busy, results hold until the next completion.
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic          clk,
  input  logic          rst,
  bcd_to_binary_if.slave bus
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM} state_t;

  state_t               state, state_nx;
  logic [4*DIGITS-1:0]  sreg, sreg_nx;
  logic [BIN_W-1:0]     acc, acc_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 done_q, done_nx;
  logic                 err_q, err_nx;
  logic [BIN_W-1:0]     bin_q, bin_nx;
  logic [BIN_W-1:0]     acc_mac;
  logic                 bad_digit;

  function automatic logic has_bad(input logic [4*DIGITS-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  assign bad_digit = has_bad(sreg);
  // acc*10 as (acc<<3)+(acc<<1), truncated to BIN_W
  assign acc_mac   = (acc << 3) + (acc << 1) + BIN_W'(sreg[4*DIGITS-1 -: 4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      acc    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      bin_q  <= '0;
    end else begin
      state  <= state_nx;
      sreg   <= sreg_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      bin_q  <= bin_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    acc_nx   = acc;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    err_nx   = err_q;
    bin_nx   = bin_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          sreg_nx  = bus.bcd_in;
          acc_nx   = '0;
          err_nx   = 1'b0;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (bad_digit) begin
          err_nx   = 1'b1;
          bin_nx   = '0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx   = '0;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        acc_nx  = acc_mac;
        sreg_nx = sreg << 4;
        cnt_nx  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DIGITS - 1)) begin
          bin_nx   = acc_mac;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.error   = err_q;
  assign bus.bin_out = bin_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: 3-digit and 4-digit instances, hand-computed results.
module tb_bcd_to_binary;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_to_binary_if #(.DIGITS(3), .BIN_W(10)) d3 ();
  bcd_to_binary_if #(.DIGITS(4), .BIN_W(14)) d4 ();

  bcd_to_binary #(.DIGITS(3), .BIN_W(10)) dut3 (.clk(clk), .rst(rst), .bus(d3));
  bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut4 (.clk(clk), .rst(rst), .bus(d4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges are counted after the edge that samples start.
  task automatic run3(input string tag, input logic [11:0] bcd, input logic [9:0] exp_bin,
                      input logic exp_err, input int exp_edges);
    int edges;
    int busy_cyc;
    d3.start  = 1'b1;
    d3.bcd_in = bcd;
    @(posedge clk); #1;
    d3.start  = 1'b0;
    d3.bcd_in = 12'hFFF;
    chk({tag, "_err_clr"}, 32'(d3.error), 32'd0);
    edges    = 0;
    busy_cyc = 0;
    while (d3.done !== 1'b1 && edges < 20) begin
      if (d3.busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_busy_cyc"}, 32'(busy_cyc), 32'(exp_edges));
    chk({tag, "_bin"}, 32'(d3.bin_out), 32'(exp_bin));
    chk({tag, "_err"}, 32'(d3.error), 32'(exp_err));
    chk({tag, "_busy_at_done"}, 32'(d3.busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(d3.done), 32'd0);
    chk({tag, "_bin_hold"}, 32'(d3.bin_out), 32'(exp_bin));
  endtask

  initial begin
    int edges;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    d3.start  = 1'b0;
    d3.bcd_in = 12'h000;
    d4.start  = 1'b0;
    d4.bcd_in = 16'h0000;
    #12;
    chk("rst_busy", 32'(d3.busy), 32'd0);
    chk("rst_done", 32'(d3.done), 32'd0);
    chk("rst_err", 32'(d3.error), 32'd0);
    chk("rst_bin", 32'(d3.bin_out), 32'd0);
    chk("rst_bin4", 32'(d4.bin_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run3("v198", 12'h198, 10'h0C6, 1'b0, 4);
    run3("v999", 12'h999, 10'h3E7, 1'b0, 4);
    run3("v000", 12'h000, 10'h000, 1'b0, 4);
    run3("v321", 12'h321, 10'h141, 1'b0, 4);
    run3("v1A5", 12'h1A5, 10'h000, 1'b1, 1);
    run3("v042", 12'h042, 10'h02A, 1'b0, 4);

    // start re-pulsed with new data mid-conversion must be ignored
    d3.start  = 1'b1;
    d3.bcd_in = 12'h123;
    @(posedge clk); #1;
    d3.bcd_in = 12'h456;
    @(posedge clk); #1;
    d3.start  = 1'b0;
    edges     = 1;
    while (d3.done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("ign_edges", 32'(edges), 32'd4);
    chk("ign_bin", 32'(d3.bin_out), 32'h07B);
    // start raised in the done cycle is accepted without a dead cycle
    d3.start  = 1'b1;
    d3.bcd_in = 12'h456;
    @(posedge clk); #1;
    d3.start  = 1'b0;
    chk("b2b_done_low", 32'(d3.done), 32'd0);
    chk("b2b_busy", 32'(d3.busy), 32'd1);
    edges = 0;
    while (d3.done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("b2b_edges", 32'(edges), 32'd4);
    chk("b2b_bin", 32'(d3.bin_out), 32'h1C8);
    @(posedge clk); #1;

    // asynchronous reset in the middle of ACCUM
    d3.start  = 1'b1;
    d3.bcd_in = 12'h777;
    @(posedge clk); #1;
    d3.start  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(d3.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(d3.busy), 32'd0);
    chk("arst_done", 32'(d3.done), 32'd0);
    chk("arst_err", 32'(d3.error), 32'd0);
    chk("arst_bin", 32'(d3.bin_out), 32'd0);
    @(posedge clk); #1;
    chk("arst_hold_done", 32'(d3.done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle_done", 32'(d3.done), 32'd0);
    run3("v305", 12'h305, 10'h131, 1'b0, 4);

    // four-digit instance
    d4.start  = 1'b1;
    d4.bcd_in = 16'h9999;
    @(posedge clk); #1;
    d4.start  = 1'b0;
    d4.bcd_in = 16'h0000;
    edges = 0;
    while (d4.done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("d4_edges", 32'(edges), 32'd5);
    chk("d4_bin", 32'(d4.bin_out), 32'd9999);
    chk("d4_err", 32'(d4.error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
